// File: rtl/irq_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : irq_sched_pkg
// Brief    : Shared state encoding, limits and code mapping for irq_sched.
// Revision : 1.0 - initial release
// ============================================================================
package irq_sched_pkg;

  // The request code is 3 bits and code 0 means "no request", so at most
  // seven sources can be distinguished.
  localparam int NSRC_MAX = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SVC  = 2'd2
  } state_e;

  // Source index i is presented to the counter as code i+1.
  function automatic logic [2:0] sel_to_code(input logic [2:0] sel);
    return sel + 3'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/irq_prio_enc.sv
`default_nettype none
// ============================================================================
// Module   : irq_prio_enc
// Brief    : Combinational priority encoder; highest set request bit wins.
// Revision : 1.0 - initial release
// ============================================================================
module irq_prio_enc #(
  parameter int NSRC = 7
) (
  input  logic [NSRC-1:0] req_i,
  output logic            valid_o,
  output logic [2:0]      idx_o
);

  // Scan upward so that later (higher) set bits override lower ones.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = 3'd0;
    for (int i = 0; i < NSRC; i++) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        idx_o   = 3'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/irq_sched.sv
`default_nettype none
// ============================================================================
// Module   : irq_sched
// Brief    : Edge-capturing interrupt scheduler. Tracks pending sources,
//            applies a software mask, presents the winning source as a
//            stable 3-bit code and holds off until the service routine ends.
// Revision : 1.0 - initial release
// ============================================================================
module irq_sched
  import irq_sched_pkg::*;
#(
  parameter int              NSRC     = 7,
  parameter logic [NSRC-1:0] MASK_RST = 7'h7F
) (
  input  logic            clk,
  input  logic            rst,        // asynchronous, active-low
  input  logic [NSRC-1:0] src,
  input  logic            mask_wr,
  input  logic [NSRC-1:0] mask_data,
  input  logic            ack,
  input  logic            inter,
  output logic [2:0]      code,
  output logic [NSRC-1:0] pending,
  output logic [NSRC-1:0] mask,
  output logic            busy,
  output logic            ovf,
  input  logic            ovf_clr
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] mask_q,    mask_d;
  logic            ovf_q,     ovf_d;
  state_e          state_q,   state_d;
  logic [2:0]      sel_q,     sel_d;
  logic            seen_hi_q, seen_hi_d;  // inter observed high during SVC
  logic            wait_q,    wait_d;     // one silent SVC cycle already spent

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] pend_clr;
  logic            win_valid;
  logic [2:0]      win_idx;

  assign rise = src & ~src_q;

  irq_prio_enc #(
    .NSRC (NSRC)
  ) u_prio_enc (
    .req_i   (pending_q & mask_q),
    .valid_o (win_valid),
    .idx_o   (win_idx)
  );

  // Pending bits: set on a rising edge, cleared on acknowledge; set wins.
  // A rising edge on an already-pending source is flagged as overflow.
  always_comb begin
    pending_d = (pending_q & ~pend_clr) | rise;
    ovf_d     = (ovf_q & ~ovf_clr) | (|(rise & pending_q));
    mask_d    = mask_wr ? mask_data : mask_q;
  end

  // Scheduler FSM: arbitration in IDLE, stable request in REQ, wait for the
  // service routine (inter high then low, or a short silent timeout) in SVC.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    seen_hi_d = seen_hi_q;
    wait_d    = wait_q;
    pend_clr  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          sel_d   = win_idx;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // The latched choice is held; a new higher source waits its turn.
        if (ack) begin
          pend_clr[sel_q] = 1'b1;
          seen_hi_d       = 1'b0;
          wait_d          = 1'b0;
          state_d         = ST_SVC;
        end else if (!mask_q[sel_q]) begin
          // Retract: the source was masked while waiting; pending is kept.
          state_d = ST_IDLE;
        end
      end
      ST_SVC: begin
        if (seen_hi_q) begin
          if (!inter) state_d = ST_IDLE;
        end else if (inter) begin
          seen_hi_d = 1'b1;
        end else if (wait_q) begin
          // Routine never raised inter within two cycles of ack.
          state_d = ST_IDLE;
        end else begin
          wait_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // All registered state, asynchronously cleared by the active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_q     <= '0;
      pending_q <= '0;
      mask_q    <= MASK_RST;
      ovf_q     <= 1'b0;
      state_q   <= ST_IDLE;
      sel_q     <= 3'd0;
      seen_hi_q <= 1'b0;
      wait_q    <= 1'b0;
    end else begin
      src_q     <= src;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      ovf_q     <= ovf_d;
      state_q   <= state_d;
      sel_q     <= sel_d;
      seen_hi_q <= seen_hi_d;
      wait_q    <= wait_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: code is derived from registered state only, so it is glitch
  // free relative to the edge and drops at once when reset is asserted.
  // --------------------------------------------------------------------------
  assign code    = (state_q == ST_REQ) ? sel_to_code(sel_q) : 3'd0;
  assign pending = pending_q;
  assign mask    = mask_q;
  assign busy    = (state_q != ST_IDLE);
  assign ovf     = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_sched
// Brief    : Self-checking bench for irq_sched: directed scenarios followed
//            by randomized traffic against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] src = '0;
  logic       mask_wr = 1'b0;
  logic [6:0] mask_data = '0;
  logic       ack = 1'b0;
  logic       inter = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [2:0] code;
  logic [6:0] pending;
  logic [6:0] mask;
  logic       busy;
  logic       ovf;

  always #5 clk = ~clk;

  irq_sched #(
    .NSRC     (7),
    .MASK_RST (7'h7F)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .src       (src),
    .mask_wr   (mask_wr),
    .mask_data (mask_data),
    .ack       (ack),
    .inter     (inter),
    .code      (code),
    .pending   (pending),
    .mask      (mask),
    .busy      (busy),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: phase 0 = idle, 1 = requesting, 2 = in service
  // --------------------------------------------------------------------------
  logic [6:0] m_pend, m_mask, m_prev;
  logic       m_ovf;
  int         m_phase, m_sel, m_silent;
  bit         m_seen;

  function automatic logic [2:0] m_code();
    return (m_phase == 1) ? 3'(m_sel + 1) : 3'd0;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_mask = 7'h7F; m_prev = '0; m_ovf = 1'b0;
    m_phase = 0; m_sel = 0; m_silent = 0; m_seen = 0;
  endtask

  task automatic model_step();
    logic [6:0] rise, elig, nxt_pend;
    rise     = src & ~m_prev;
    elig     = m_pend & m_mask;
    nxt_pend = m_pend;
    m_ovf    = (m_ovf && !ovf_clr) || ((rise & m_pend) != 0);
    case (m_phase)
      0: if (elig != 0) begin
           for (int i = 6; i >= 0; i--) if (elig[i]) begin m_sel = i; break; end
           m_phase = 1;
         end
      1: if (ack) begin
           nxt_pend[m_sel] = 1'b0;
           m_phase = 2; m_seen = 0; m_silent = 0;
         end else if (!m_mask[m_sel]) m_phase = 0;
      default: begin
         if (m_seen) begin
           if (!inter) m_phase = 0;
         end else if (inter) m_seen = 1;
         else begin
           m_silent++;
           if (m_silent == 2) m_phase = 0;
         end
      end
    endcase
    m_pend = nxt_pend | rise;
    if (mask_wr) m_mask = mask_data;
    m_prev = src;
  endtask

  task automatic compare_all();
    check("code",    code,    m_code());
    check("pending", pending, m_pend);
    check("mask",    mask,    m_mask);
    check("busy",    busy,    m_phase != 0);
    check("ovf",     ovf,     m_ovf);
  endtask

  // One clock: model follows the same inputs, outputs checked 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic service(input int hi_cycles);
    ack = 1'b1; tick(); ack = 1'b0;
    inter = 1'b1; repeat (hi_cycles) tick();
    inter = 1'b0; tick();
  endtask

  logic [6:0] tgl;

  initial begin
    model_reset();
    #12;
    compare_all();
    check("reset_mask", mask, 7'h7F);
    @(negedge clk); rst = 1'b1;

    // Single source, full handshake
    src = 7'h04; tick(); check("t1_pend", pending, 7'h04);
    src = 7'h00; tick(); check("t1_code", code, 3'd3);
    ack = 1'b1; tick(); ack = 1'b0;
    check("t1_ack_code", code, 3'd0); check("t1_ack_pend", pending, 7'h00);
    inter = 1'b1; repeat (5) tick();
    inter = 1'b0; tick(); check("t1_busy", busy, 1'b0);

    // Simultaneous sources: highest first, then the other; then silent timeout
    src = 7'h22; tick(); src = 7'h00; tick();
    check("t2_first", code, 3'd6);
    service(2);
    tick(); check("t2_second", code, 3'd2);
    ack = 1'b1; tick(); ack = 1'b0;
    tick(); check("t2_tmo_busy1", busy, 1'b1);
    tick(); check("t2_tmo_busy0", busy, 1'b0);

    // No re-arbitration while requesting
    src = 7'h01; tick(); src = 7'h00; tick(); check("t3_code1", code, 3'd1);
    src = 7'h40; tick(); src = 7'h00; tick(); check("t3_hold", code, 3'd1);
    service(1);
    tick(); check("t3_code7", code, 3'd7);
    service(1);

    // Masking while requesting retracts, unmasking restores
    src = 7'h08; tick(); src = 7'h00; tick(); check("t4_code4", code, 3'd4);
    mask_wr = 1'b1; mask_data = 7'h77; tick(); mask_wr = 1'b0;
    tick();
    check("t4_retract", code, 3'd0); check("t4_idle", busy, 1'b0);
    check("t4_pend", pending, 7'h08);
    mask_wr = 1'b1; mask_data = 7'h7F; tick(); mask_wr = 1'b0;
    tick(); check("t4_again", code, 3'd4);
    service(1);

    // Overflow on a second rise without ack
    src = 7'h10; tick(); src = 7'h00; tick();
    src = 7'h10; tick(); src = 7'h00;
    check("t5_ovf", ovf, 1'b1); check("t5_pend4", pending[4], 1'b1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check("t5_ovfclr", ovf, 1'b0);
    check("t5_code5", code, 3'd5);

    // Asynchronous reset mid-request
    #2; rst = 1'b0; #1;
    model_reset();
    check("t6_code", code, 3'd0); check("t6_pend", pending, 7'h00);
    check("t6_mask", mask, 7'h7F); check("t6_busy", busy, 1'b0);
    @(negedge clk); rst = 1'b1;

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      tgl = '0;
      for (int b = 0; b < 7; b++) tgl[b] = ($urandom_range(0, 7) == 0);
      src       = src ^ tgl;
      mask_wr   = ($urandom_range(0, 15) == 0);
      mask_data = 7'($urandom) | 7'($urandom);
      ovf_clr   = ($urandom_range(0, 15) == 0);
      if (m_phase == 1) ack = ($urandom_range(0, 2) == 0);
      else              ack = ($urandom_range(0, 19) == 0);
      if (m_phase == 2) begin
        if (inter) inter = ($urandom_range(0, 2) != 0);
        else       inter = ($urandom_range(0, 2) == 0);
      end else begin
        inter = ($urandom_range(0, 29) == 0);
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
